// File: rtl/epp_controller_pkg.sv
// Shared types and constants for the EPP device-side controller.
package epp_controller_pkg;

  typedef enum logic [1:0] {
    ST_ARM,
    ST_IDLE,
    ST_BUSY,
    ST_HOLD
  } state_e;

  // Kind of host cycle being serviced, captured at the IDLE decision.
  typedef struct packed {
    logic is_addr;
    logic is_read;
  } cyc_t;

  localparam int         DEFAULT_TIMEOUT = 255;
  localparam logic [7:0] TIMEOUT_RDATA   = 8'hFF;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Clearing to zero makes active-low strobes look asserted until they are
  // genuinely seen idle, which is what lets the ARM state reject a stale strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep both stages as distinct flops.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/epp_controller.sv
// EPP strobe/wait handshake with an 8-bit address register, bridging host
// data cycles onto a simple request/ack register bus.
module epp_controller
  import epp_controller_pkg::*;
#(
  parameter int TIMEOUT  = DEFAULT_TIMEOUT,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       usb_write,
  input  logic       usb_astb,
  input  logic       usb_dstb,
  inout  wire  [7:0] usb_db,
  output logic       usb_wait,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_re,
  input  logic [7:0] bus_rdata,
  input  logic       bus_ack,
  output logic       err
);

  localparam int             CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic write_s, astb_s, dstb_s;

  sync2 #(.WIDTH(3)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   ({usb_write, usb_astb, usb_dstb}),
    .q_o   ({write_s, astb_s, dstb_s})
  );

  state_e           state_q, state_d;
  cyc_t             cyc_q, cyc_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdq_q, rdq_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ARM;
      cyc_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdq_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdq_q   <= rdq_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Synced level of whichever strobe opened the cycle being held.
  assign strobe_s = cyc_q.is_addr ? astb_s : dstb_s;

  always_comb begin
    // NOTE: every next-state value defaults to its register so no path infers a latch.
    state_d = state_q;
    cyc_d   = cyc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdq_d   = rdq_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_ARM: begin
        if (astb_s && dstb_s) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!astb_s) begin
          cyc_d = '{is_addr: 1'b1, is_read: write_s};
          if (!write_s) begin
            addr_d = usb_db;
            err_d  = 1'b0;
          end
          state_d = ST_HOLD;
        end else if (!dstb_s) begin
          cyc_d = '{is_addr: 1'b0, is_read: write_s};
          if (!write_s) wdata_d = usb_db;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus_ack) begin
          if (cyc_q.is_read) rdq_d = bus_rdata;
          state_d = ST_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          err_d = 1'b1;
          if (cyc_q.is_read) rdq_d = TIMEOUT_RDATA;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (strobe_s) begin
          if (AUTO_INC && !cyc_q.is_addr) addr_d = addr_q + 8'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_ARM;
    endcase
  end

  assign usb_wait  = (state_q == ST_HOLD);
  assign bus_we    = (state_q == ST_BUSY) && !cyc_q.is_read;
  assign bus_re    = (state_q == ST_BUSY) && cyc_q.is_read;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign err       = err_q;

  // The bus is released the instant the raw strobe rises, not two clocks later.
  logic       db_oe;
  logic [7:0] db_out;
  assign db_oe  = (state_q == ST_HOLD) && cyc_q.is_read &&
                  (cyc_q.is_addr ? !usb_astb : !usb_dstb);
  assign db_out = cyc_q.is_addr ? addr_q : rdq_q;
  assign usb_db = db_oe ? db_out : 8'hzz;

endmodule

// File: tb/tb_epp_controller.sv
// Self-checking bench for epp_controller: directed scenarios plus randomized
// host cycles checked against a transaction-level model.
module tb_epp_controller;

  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic       usb_write, usb_astb, usb_dstb;
  wire  [7:0] usb_db;
  logic       usb_wait;
  logic [7:0] bus_addr, bus_wdata, bus_rdata;
  logic       bus_we, bus_re, bus_ack, err;

  logic [7:0] tb_db;
  logic       tb_db_oe;
  assign usb_db = tb_db_oe ? tb_db : 8'hzz;

  epp_controller #(.TIMEOUT(TIMEOUT), .AUTO_INC(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .usb_write (usb_write),
    .usb_astb  (usb_astb),
    .usb_dstb  (usb_dstb),
    .usb_db    (usb_db),
    .usb_wait  (usb_wait),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .err       (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Host-visible model state: address register and sticky error flag.
  logic [7:0] m_addr;
  logic       m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive a distinctive value from the host side; it reads back intact only
  // when the DUT has let go of the data bus.
  task automatic check_released(input string tag);
    #1 tb_db = 8'h5A;
    tb_db_oe = 1'b1;
    #1 check(tag, usb_db, 8'h5A);
    tb_db_oe = 1'b0;
  endtask

  task automatic finish_strobe(input bit rd, input bit is_addr);
    int t;
    t = 0;
    if (is_addr) usb_astb = 1'b1;
    else         usb_dstb = 1'b1;
    if (rd) check_released("db_release");
    tb_db_oe = 1'b0;
    while (usb_wait && t < 20) begin
      tick();
      t++;
    end
    check("wait_drop_lat", t, 3);
    check("addr_after", bus_addr, m_addr);
    tick();
  endtask

  task automatic addr_cycle(input bit rd, input logic [7:0] v);
    int t;
    bit req;
    t = 0;
    req = 1'b0;
    usb_write = rd;
    tb_db = v;
    tb_db_oe = !rd;
    usb_astb = 1'b0;
    while (!usb_wait && t < 20) begin
      tick();
      t++;
      if (bus_we || bus_re) req = 1'b1;
    end
    check("addr_wait_lat", t, 3);
    check("addr_no_req", req, 0);
    if (!rd) begin
      m_addr = v;
      m_err  = 1'b0;
    end
    check("addr_reg", bus_addr, m_addr);
    check("addr_err", err, m_err);
    if (rd) check("addr_rd_db", usb_db, m_addr);
    finish_strobe(rd, 1'b1);
  endtask

  // lat = request cycle on which the bus acks (1 = same cycle); 0 = never.
  task automatic data_cycle(input bit rd, input logic [7:0] v, input int lat,
                            input logic [7:0] rdata);
    int t, n, exp_n;
    bit stable;
    logic [7:0] exp_db;
    t = 0;
    n = 0;
    stable = 1'b1;
    usb_write = rd;
    tb_db = v;
    tb_db_oe = !rd;
    bus_rdata = 8'($urandom);
    usb_dstb = 1'b0;
    while (!(bus_we || bus_re) && t < 20) begin
      tick();
      t++;
    end
    check("req_lat", t, 3);
    check("req_kind", {bus_we, bus_re}, rd ? 2'b01 : 2'b10);
    while ((bus_we || bus_re) && n < TIMEOUT + 20) begin
      n++;
      if (bus_addr !== m_addr || (!rd && bus_wdata !== v) ||
          bus_we !== !rd || bus_re !== rd) stable = 1'b0;
      if (n == lat) begin
        bus_ack = 1'b1;
        bus_rdata = rdata;
      end
      tick();
      bus_ack = 1'b0;
      bus_rdata = 8'($urandom);
    end
    exp_n  = (lat >= 1 && lat <= TIMEOUT) ? lat : TIMEOUT;
    exp_db = (lat >= 1 && lat <= TIMEOUT) ? rdata : 8'hFF;
    if (lat == 0) m_err = 1'b1;
    check("req_len", n, exp_n);
    check("req_stable", stable, 1);
    check("wait_after_req", usb_wait, 1);
    check("data_err", err, m_err);
    if (rd) check("data_rd_db", usb_db, exp_db);
    m_addr = m_addr + 8'd1;
    finish_strobe(rd, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int req_seen;
    reset = 1'b1;
    usb_write = 1'b0;
    usb_astb = 1'b1;
    usb_dstb = 1'b1;
    bus_ack = 1'b0;
    bus_rdata = 8'h00;
    tb_db = 8'h00;
    tb_db_oe = 1'b0;
    m_addr = 8'h00;
    m_err = 1'b0;
    repeat (3) tick();

    check("rst_wait", usb_wait, 0);
    check("rst_addr", bus_addr, 8'h00);
    check("rst_wdata", bus_wdata, 8'h00);
    check("rst_we", bus_we, 0);
    check("rst_re", bus_re, 0);
    check("rst_err", err, 0);
    check_released("rst_db_release");
    reset = 1'b0;
    repeat (4) tick();

    addr_cycle(1'b0, 8'h42);
    addr_cycle(1'b0, 8'h10);
    data_cycle(1'b0, 8'hA5, 2, 8'h00);
    data_cycle(1'b1, 8'h00, 3, 8'h3C);
    data_cycle(1'b0, 8'h66, 1, 8'h00);
    data_cycle(1'b1, 8'h00, 0, 8'h00);
    addr_cycle(1'b0, 8'h20);
    addr_cycle(1'b0, 8'hFF);
    data_cycle(1'b0, 8'h5C, 1, 8'h00);
    addr_cycle(1'b1, 8'h00);

    for (int i = 0; i < 24; i++) begin
      int kind, lat;
      kind = $urandom_range(0, 3);
      lat  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      case (kind)
        0: addr_cycle(1'b0, 8'($urandom));
        1: addr_cycle(1'b1, 8'h00);
        2: data_cycle(1'b0, 8'($urandom), lat, 8'h00);
        default: data_cycle(1'b1, 8'h00, lat, 8'($urandom));
      endcase
    end

    // Reset while a write sits in BUSY with dstb still low.
    usb_write = 1'b0;
    tb_db = 8'h77;
    tb_db_oe = 1'b1;
    usb_dstb = 1'b0;
    repeat (5) tick();
    check("pre_rst_busy", bus_we, 1);
    reset = 1'b1;
    repeat (2) tick();
    check("mid_rst_we", bus_we, 0);
    check("mid_rst_wait", usb_wait, 0);
    check("mid_rst_addr", bus_addr, 8'h00);
    check("mid_rst_err", err, 0);
    reset = 1'b0;
    m_addr = 8'h00;
    m_err = 1'b0;
    req_seen = 0;
    repeat (12) begin
      tick();
      if (bus_we || bus_re || usb_wait) req_seen++;
    end
    check("stale_strobe_ignored", req_seen, 0);
    usb_dstb = 1'b1;
    tb_db_oe = 1'b0;
    repeat (4) tick();
    data_cycle(1'b0, 8'h33, 1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
